tlb_search_arbiter: RTL and testbench

//  Shares the single TLB search port between three requesters: IF fetch translation,
//  EX/MEM load-store translation, and the TLBSRCH instruction.

---
 rtl/tlb_search_arbiter.sv | 89 ++++++++
 tb/tb_tlb_search_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/tlb_search_arbiter.sv
// tlb_search_arbiter: shares one TLB search port between IF, EX and TLBSRCH (grant -> lookup -> registered response); ports: clk/reset, {inst,data,srch}_{req,va,gnt}, cur_asid, tlb_busy, flush, s_* TLB search bus, rsp_* response
module tlb_search_arbiter #(
  parameter int TLBNUM       = 16,
  parameter int IDXW         = $clog2(TLBNUM),
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_req,
  input  logic [31:0]     inst_va,
  output logic            inst_gnt,
  input  logic            data_req,
  input  logic [31:0]     data_va,
  output logic            data_gnt,
  input  logic            srch_req,
  input  logic [31:0]     srch_va,
  output logic            srch_gnt,
  input  logic [9:0]      cur_asid,
  input  logic            tlb_busy,
  input  logic            flush,
  output logic [18:0]     s_vppn,
  output logic            s_va_bit12,
  output logic [9:0]      s_asid,
  input  logic            s_found,
  input  logic [IDXW-1:0] s_index,
  input  logic [19:0]     s_ppn,
  input  logic [5:0]      s_ps,
  input  logic [1:0]      s_plv,
  input  logic [1:0]      s_mat,
  input  logic            s_d,
  input  logic            s_v,
  output logic            rsp_valid,
  output logic [1:0]      rsp_id,
  output logic            rsp_found,
  output logic [IDXW-1:0] rsp_index,
  output logic [19:0]     rsp_ppn,
  output logic [5:0]      rsp_ps,
  output logic [1:0]      rsp_plv,
  output logic [1:0]      rsp_mat,
  output logic            rsp_d,
  output logic            rsp_v
);
  logic [3:0]  r_starve;
  logic        r_s1_valid;
  logic [1:0]  r_s1_id;
  logic [19:0] r_s1_va;
  logic [9:0]  r_s1_asid;
  logic        w_starved;
  logic        w_any;
  logic        w_s2_next;
  logic [1:0]  w_id;
  logic [19:0] w_va;
  logic        w_unused;
  assign w_starved = r_starve == 4'(STARVE_LIMIT);
  assign srch_gnt  = !tlb_busy && srch_req;
  // once IF has starved long enough it overtakes EX, never SRCH
  assign data_gnt  = !tlb_busy && !flush && data_req && !srch_req && !(w_starved && inst_req);
  assign inst_gnt  = !tlb_busy && !flush && inst_req && !srch_req && (w_starved || !data_req);
  assign w_any     = inst_gnt || data_gnt || srch_gnt;
  assign w_id      = srch_gnt ? 2'b11 : data_gnt ? 2'b10 : 2'b01;
  assign w_va      = srch_gnt ? srch_va[31:12] : data_gnt ? data_va[31:12] : inst_va[31:12];
  // flush kills a pipeline-owned entry on its way into stage 2; SRCH entries survive
  assign w_s2_next = r_s1_valid && !(flush && r_s1_id != 2'b11);
  assign s_vppn     = r_s1_va[19:1];
  assign s_va_bit12 = r_s1_va[0];
  assign s_asid     = r_s1_asid;
  assign w_unused   = ^{inst_va[11:0], data_va[11:0], srch_va[11:0]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_s1_va    <= '0;
      r_s1_asid  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      {rsp_found, rsp_index, rsp_ppn, rsp_ps, rsp_plv, rsp_mat, rsp_d, rsp_v} <= '0;
    end else begin
      r_starve   <= (!inst_req || inst_gnt) ? 4'd0 :
                    (!flush && !tlb_busy && !w_starved) ? r_starve + 4'd1 : r_starve;
      r_s1_valid <= w_any;
      if (w_any) {r_s1_id, r_s1_va, r_s1_asid} <= {w_id, w_va, cur_asid};
      rsp_valid  <= w_s2_next;
      rsp_id     <= w_s2_next ? r_s1_id : 2'b00;
      if (w_s2_next) {rsp_found, rsp_index, rsp_ppn, rsp_ps, rsp_plv, rsp_mat, rsp_d, rsp_v} <=
        {s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v};
    end
  end
endmodule

// File: tb/tb_tlb_search_arbiter.sv
// tb_tlb_search_arbiter: table-driven grant vectors with a response scoreboard for tlb_search_arbiter
module tb_tlb_search_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req, data_req, srch_req, tlb_busy, flush;
  logic [31:0] inst_va, data_va, srch_va;
  logic [9:0]  cur_asid;
  logic        inst_gnt, data_gnt, srch_gnt;
  logic [18:0] s_vppn;
  logic        s_va_bit12;
  logic [9:0]  s_asid;
  logic        s_found, s_d, s_v;
  logic [3:0]  s_index;
  logic [19:0] s_ppn;
  logic [5:0]  s_ps;
  logic [1:0]  s_plv, s_mat;
  logic        rsp_valid, rsp_found, rsp_d, rsp_v;
  logic [1:0]  rsp_id, rsp_plv, rsp_mat;
  logic [3:0]  rsp_index;
  logic [19:0] rsp_ppn;
  logic [5:0]  rsp_ps;
  typedef struct packed {
    logic [1:0]  id;
    logic        found;
    logic [3:0]  index;
    logic [19:0] ppn;
    logic [5:0]  ps;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } rsp_t;
  typedef struct {
    int   due;
    rsp_t r;
  } sb_t;
  typedef struct {
    logic       ir, dr, sr, busy, fl;
    logic [2:0] gnt;
  } vec_t;
  sb_t  q[$];
  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  rsp_t w_tlb, act;
  always #5 clk = ~clk;
  tlb_search_arbiter #(.TLBNUM(16), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_va(inst_va), .inst_gnt(inst_gnt),
    .data_req(data_req), .data_va(data_va), .data_gnt(data_gnt),
    .srch_req(srch_req), .srch_va(srch_va), .srch_gnt(srch_gnt),
    .cur_asid(cur_asid), .tlb_busy(tlb_busy), .flush(flush),
    .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .s_ppn(s_ppn), .s_ps(s_ps),
    .s_plv(s_plv), .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_found(rsp_found), .rsp_index(rsp_index),
    .rsp_ppn(rsp_ppn), .rsp_ps(rsp_ps), .rsp_plv(rsp_plv), .rsp_mat(rsp_mat),
    .rsp_d(rsp_d), .rsp_v(rsp_v)
  );
  function automatic rsp_t tlb_fn(logic [19:0] vpn, logic [9:0] asid);
    rsp_t t;
    t.id    = 2'b00;
    t.found = ~vpn[7];
    t.index = vpn[3:0] ^ asid[3:0];
    t.ppn   = vpn ^ 20'h1CABC ^ {asid, 10'h000};
    t.ps    = vpn[0] ? 6'd21 : 6'd12;
    t.plv   = vpn[2:1];
    t.mat   = asid[1:0];
    t.d     = vpn[5];
    t.v     = vpn[6];
    return t;
  endfunction
  assign w_tlb = tlb_fn({s_vppn, s_va_bit12}, s_asid);
  assign {s_found, s_index, s_ppn, s_ps, s_plv, s_mat, s_d, s_v} =
    {w_tlb.found, w_tlb.index, w_tlb.ppn, w_tlb.ps, w_tlb.plv, w_tlb.mat, w_tlb.d, w_tlb.v};
  assign act = {rsp_id, rsp_found, rsp_index, rsp_ppn, rsp_ps, rsp_plv, rsp_mat, rsp_d, rsp_v};
  function automatic vec_t mk(logic ir, logic dr, logic sr, logic busy, logic fl, logic [2:0] g);
    vec_t v;
    v.ir = ir; v.dr = dr; v.sr = sr; v.busy = busy; v.fl = fl; v.gnt = g;
    return v;
  endfunction
  task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, a, e);
    end
  endtask
  task automatic idle_inputs();
    {inst_req, data_req, srch_req, tlb_busy, flush} = '0;
    inst_va = '0; data_va = '0; srch_va = '0; cur_asid = '0;
  endtask
  task automatic step(input vec_t v, input int k);
    rsp_t e;
    logic [31:0] va;
    @(negedge clk);
    cyc++;
    {inst_req, data_req, srch_req, tlb_busy, flush} = {v.ir, v.dr, v.sr, v.busy, v.fl};
    inst_va  = 32'h1C000123 ^ (32'(k) << 14);
    data_va  = 32'h00402ABC ^ (32'(k) << 13);
    srch_va  = 32'h00BEE000 ^ (32'(k) << 15);
    cur_asid = 10'(k * 37);
    #1;
    chk("gnt", {125'd0, inst_gnt, data_gnt, srch_gnt}, {125'd0, v.gnt});
    if (v.fl)
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].due == cyc + 1 && q[i].r.id != 2'b11) q.delete(i);
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rsp", {88'd0, rsp_valid, act}, {88'd0, 1'b1, q[0].r});
      void'(q.pop_front());
    end else chk("rsp_idle", {127'd0, rsp_valid}, 128'd0);
    if (v.gnt != 3'b000) begin
      va = v.gnt[0] ? srch_va : v.gnt[1] ? data_va : inst_va;
      e = tlb_fn(va[31:12], cur_asid);
      e.id = v.gnt[0] ? 2'b11 : v.gnt[1] ? 2'b10 : 2'b01;
      q.push_back('{cyc + 2, e});
    end
  endtask
  initial begin
    idle_inputs();
    vq.push_back(mk(1,0,0,0,0,3'b100));
    repeat (2) vq.push_back(mk(0,0,0,0,0,3'b000));
    vq.push_back(mk(1,1,1,0,0,3'b001));
    vq.push_back(mk(1,1,0,0,0,3'b010));
    vq.push_back(mk(1,0,0,0,0,3'b100));
    repeat (2) vq.push_back(mk(0,0,0,0,0,3'b000));
    repeat (4) vq.push_back(mk(1,1,0,0,0,3'b010));
    vq.push_back(mk(1,1,0,0,0,3'b100));
    vq.push_back(mk(0,1,0,0,0,3'b010));
    vq.push_back(mk(0,0,0,0,0,3'b000));
    vq.push_back(mk(1,0,0,0,0,3'b100));
    vq.push_back(mk(0,0,0,0,1,3'b000));
    vq.push_back(mk(0,0,0,0,0,3'b000));
    vq.push_back(mk(0,0,1,0,0,3'b001));
    vq.push_back(mk(1,1,1,0,1,3'b001));
    vq.push_back(mk(1,1,0,0,0,3'b010));
    vq.push_back(mk(0,0,0,0,1,3'b000));
    vq.push_back(mk(0,0,0,0,0,3'b000));
    vq.push_back(mk(0,1,0,0,0,3'b010));
    repeat (3) vq.push_back(mk(1,1,1,1,0,3'b000));
    vq.push_back(mk(1,1,1,0,0,3'b001));
    vq.push_back(mk(1,1,0,0,0,3'b010));
    vq.push_back(mk(1,0,0,0,0,3'b100));
    repeat (4) vq.push_back(mk(1,1,0,0,0,3'b010));
    vq.push_back(mk(1,1,1,0,0,3'b001));
    vq.push_back(mk(1,1,0,0,0,3'b100));
    vq.push_back(mk(0,1,0,0,0,3'b010));
    repeat (2) vq.push_back(mk(0,0,0,0,0,3'b000));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset", {55'd0, inst_gnt, data_gnt, srch_gnt, rsp_valid, act, s_vppn, s_va_bit12, s_asid}, 128'd0);
    reset = 1'b0;
    for (int k = 0; k < vq.size(); k++) begin
      step(vq[k], k);
      if (k == 2) begin
        chk("if_ppn", {108'd0, rsp_ppn}, {108'd0, 20'h00ABC});
        chk("s_hold", {108'd0, s_vppn, s_va_bit12}, {108'd0, 20'h1C000});
      end
    end
    step(mk(1,0,0,0,0,3'b100), vq.size());
    step(mk(0,1,0,0,0,3'b010), vq.size() + 1);
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("reset_mid", {58'd0, rsp_valid, act, s_vppn, s_va_bit12, s_asid}, 128'd0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step(mk(0,0,0,0,0,3'b000), 0);
    chk("sb_empty", 128'(q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
